// File: rtl/bcd_scan_counter_pkg.sv
// bcd_scan_counter_pkg: shared constants and helpers for the BCD scan counter
package bcd_scan_counter_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] DIG_SEL [NUM_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  function automatic logic [3:0] fix_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction
endpackage

// File: rtl/bcd_scan_counter_if.sv
// bcd_scan_counter_if: control inputs, count outputs and display scan outputs
interface bcd_scan_counter_if;
  logic        EN;
  logic        UP;
  logic        LOAD;
  logic [15:0] D;
  logic        LZB;
  logic [15:0] Q;
  logic        CO;
  logic [3:0]  A;
  logic [3:0]  DIG_N;
  logic        BI_N;
  logic        LE;
  modport master (output EN, UP, LOAD, D, LZB, input Q, CO, A, DIG_N, BI_N, LE);
  modport slave (input EN, UP, LOAD, D, LZB, output Q, CO, A, DIG_N, BI_N, LE);
endinterface

// File: rtl/bcd_scan_counter_digit.sv
// bcd_digit: one up/down decade with load; c_o ripples to the next decade
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] d_i,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       c_i,
  output logic [3:0] q_o,
  output logic       c_o
);
  logic [3:0] q_q, q_d;
  logic       step;
  assign step = en_i & c_i;
  assign c_o  = step & (up_i ? (q_q == BCD_MAX) : (q_q == 4'd0));
  always_comb begin
    q_d = q_q;
    if (load_i) q_d = fix_bcd(d_i);
    else if (step) q_d = up_i ? ((q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1)
                              : ((q_q == 4'd0) ? BCD_MAX : q_q - 4'd1);
  end
  always_ff @(posedge clk)
    if (!rst_n) q_q <= 4'd0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: 4-decade BCD up/down counter with multiplexed display scan
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input logic CLK,
  input logic RST_N,
  bcd_scan_counter_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [NUM_DIGITS:0]     c;
  logic [4*NUM_DIGITS-1:0] q;
  logic [NUM_DIGITS-1:0]   nz;
  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    co_q, co_d, bi_n_q, bi_n_d;
  logic [3:0]              a_q, a_d, dig_n_q, dig_n_d;
  logic                    wrap;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk    (CLK),
      .rst_n  (RST_N),
      .load_i (bus.LOAD),
      .d_i    (bus.D[4*i+:4]),
      .en_i   (bus.EN),
      .up_i   (bus.UP),
      .c_i    (c[i]),
      .q_o    (q[4*i+:4]),
      .c_o    (c[i+1])
    );
    assign nz[i] = |q[4*i+:4];
  end
  assign wrap = (div_q == DW'(SCAN_DIV - 1));
  // Blank digit k only when it and every more significant digit are zero
  always_comb begin
    div_d   = wrap ? '0 : div_q + 1'b1;
    idx_d   = wrap ? idx_q + 1'b1 : idx_q;
    co_d    = !bus.LOAD & c[NUM_DIGITS];
    a_d     = q[{idx_q, 2'b00}+:4];
    dig_n_d = DIG_SEL[idx_q];
    bi_n_d  = !(bus.LZB && (idx_q != '0) && ((nz >> idx_q) == '0));
  end
  always_ff @(posedge CLK)
    if (!RST_N) begin
      div_q   <= '0;
      idx_q   <= '0;
      co_q    <= 1'b0;
      a_q     <= 4'd0;
      dig_n_q <= DIG_SEL[0];
      bi_n_q  <= 1'b1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      co_q    <= co_d;
      a_q     <= a_d;
      dig_n_q <= dig_n_d;
      bi_n_q  <= bi_n_d;
    end
  assign bus.Q     = q;
  assign bus.CO    = co_q;
  assign bus.A     = a_q;
  assign bus.DIG_N = dig_n_q;
  assign bus.BI_N  = bi_n_q;
  assign bus.LE    = 1'b0;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: scoreboard bench; driver queues expectations per cycle, monitor checks them
module tb_bcd_scan_counter;
  localparam int MQ = 1, MCO = 2, MA = 4, MD = 8, MB = 16, ALL = 31;
  typedef struct {
    int          t;
    string       nm;
    int          m;
    logic [15:0] q;
    logic        co;
    logic [3:0]  a;
    logic [3:0]  dig;
    logic        bi;
  } exp_t;
  logic CLK = 1'b0;
  logic RST_N;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t cur;
  bcd_scan_counter_if bus ();
  bcd_scan_counter #(.SCAN_DIV(4)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endfunction
  always @(negedge CLK)
    while (sb.size() != 0 && sb[0].t <= cyc) begin
      cur = sb.pop_front();
      if (cur.t < cyc) chk({cur.nm, "_missed"}, cyc, cur.t);
      if ((cur.m & MQ) != 0) chk({cur.nm, "_q"}, int'(bus.Q), int'(cur.q));
      if ((cur.m & MCO) != 0) chk({cur.nm, "_co"}, int'(bus.CO), int'(cur.co));
      if ((cur.m & MA) != 0) chk({cur.nm, "_a"}, int'(bus.A), int'(cur.a));
      if ((cur.m & MD) != 0) chk({cur.nm, "_dign"}, int'(bus.DIG_N), int'(cur.dig));
      if ((cur.m & MB) != 0) chk({cur.nm, "_bin"}, int'(bus.BI_N), int'(cur.bi));
      chk({cur.nm, "_le"}, int'(bus.LE), 0);
    end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic ex(int dt, string nm, int m, logic [15:0] q, logic co,
                    logic [3:0] a = 4'd0, logic [3:0] dig = 4'b1110, logic bi = 1'b1);
    exp_t e;
    e = '{cyc + dt, nm, m, q, co, a, dig, bi};
    sb.push_back(e);
  endtask
  task automatic run_scan(logic [15:0] d, logic lzb, logic [3:0] bv);
    int k;
    RST_N = 1'b0; bus.LOAD = 1'b0; bus.EN = 1'b0;
    tick();
    tick();
    RST_N = 1'b1; bus.LOAD = 1'b1; bus.D = d; bus.LZB = lzb;
    ex(1, "scan_load", MQ | MCO, d, 1'b0);
    for (int i = 0; i < 16; i++) begin
      k = (i / 4 + 1) % 4;
      ex(5 + i, "scan", MA | MD | MB, 16'h0, 1'b0, d[4*k+:4], ~(4'b0001 << k), bv[k]);
    end
    tick();
    bus.LOAD = 1'b0;
    repeat (19) tick();
  endtask
  initial begin
    RST_N = 1'b0; bus.EN = 1'b0; bus.UP = 1'b1; bus.LOAD = 1'b0; bus.D = 16'h0; bus.LZB = 1'b0;
    tick();
    ex(1, "rst_hold", ALL, 16'h0000, 1'b0);
    tick();
    RST_N = 1'b1;
    ex(1, "rst_rel", ALL, 16'h0000, 1'b0);
    tick();
    bus.LOAD = 1'b1; bus.D = 16'h9998; ex(1, "ld9998", MQ | MCO, 16'h9998, 1'b0); tick();
    bus.LOAD = 1'b0; bus.EN = 1'b1; bus.UP = 1'b1; ex(1, "up9999", MQ | MCO, 16'h9999, 1'b0); tick();
    ex(1, "upwrap", MQ | MCO, 16'h0000, 1'b1); tick();
    bus.EN = 1'b0; ex(1, "hold", MQ | MCO, 16'h0000, 1'b0); tick();
    bus.LOAD = 1'b1; bus.D = 16'h0001; ex(1, "ld0001", MQ | MCO, 16'h0001, 1'b0); tick();
    bus.LOAD = 1'b0; bus.EN = 1'b1; bus.UP = 1'b0; ex(1, "dn0000", MQ | MCO, 16'h0000, 1'b0); tick();
    ex(1, "dnwrap", MQ | MCO, 16'h9999, 1'b1); tick();
    bus.EN = 1'b0; bus.LOAD = 1'b1; bus.D = 16'h0100; ex(1, "ld0100", MQ | MCO, 16'h0100, 1'b0); tick();
    bus.LOAD = 1'b0; bus.EN = 1'b1; ex(1, "dn0099", MQ | MCO, 16'h0099, 1'b0); tick();
    bus.EN = 1'b0; bus.UP = 1'b1; bus.LOAD = 1'b1; bus.D = 16'hA3F7;
    ex(1, "ld_inval", MQ | MCO, 16'h0307, 1'b0); tick();
    bus.D = 16'h0999; ex(1, "ld0999", MQ | MCO, 16'h0999, 1'b0); tick();
    bus.LOAD = 1'b0; bus.EN = 1'b1; ex(1, "up1000", MQ | MCO, 16'h1000, 1'b0); tick();
    ex(1, "up1001", MQ | MCO, 16'h1001, 1'b0); tick();
    bus.UP = 1'b0; ex(1, "dn1000", MQ | MCO, 16'h1000, 1'b0); tick();
    ex(1, "dn0999", MQ | MCO, 16'h0999, 1'b0); tick();
    bus.UP = 1'b1; bus.LOAD = 1'b1; bus.D = 16'h9999; ex(1, "ld_pri", MQ | MCO, 16'h9999, 1'b0); tick();
    bus.D = 16'h0000; ex(1, "ld_over_wrap", MQ | MCO, 16'h0000, 1'b0); tick();
    bus.D = 16'h9999; ex(1, "ld9999", MQ | MCO, 16'h9999, 1'b0); tick();
    bus.LOAD = 1'b0; RST_N = 1'b0; ex(1, "rst_midcount", ALL, 16'h0000, 1'b0); tick();
    RST_N = 1'b1; bus.EN = 1'b0;
    run_scan(16'h4321, 1'b0, 4'b1111);
    run_scan(16'h0050, 1'b1, 4'b0011);
    run_scan(16'h0050, 1'b0, 4'b1111);
    run_scan(16'h0000, 1'b1, 4'b0001);
    run_scan(16'h0205, 1'b1, 4'b0111);
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 50000, sets the clock cycles each digit is displayed per scan step; the legal range SHALL be at least 2.
REQ-002 Port CLK, input, 1 bit: the single system clock; all state SHALL change only on the CLK rising edge.
REQ-003 Port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port EN, input, 1 bit: count enable; each CLK cycle with EN=1 SHALL count one step.
REQ-005 Port UP, input, 1 bit: count direction; 1 counts up, 0 counts down.
REQ-006 Port LOAD, input, 1 bit: synchronous parallel load of D.
REQ-007 Port D, input, 16 bits: load value as 4 BCD digits; D[3:0] is the units digit.
REQ-008 Port LZB, input, 1 bit: leading-zero blanking enable.
REQ-009 Port Q, output, 16 bits: current count as 4 BCD digits, registered.
REQ-010 Port CO, output, 1 bit: carry/borrow pulse, registered.
REQ-011 Port A, output, 4 bits: BCD code of the scanned digit, driving the downstream 7-segment decoder input A.
REQ-012 Port DIG_N, output, 4 bits: active-low one-hot digit select; DIG_N[0] selects the units digit.
REQ-013 Port BI_N, output, 1 bit: blanking to the decoder, active-low.
REQ-014 Port LE, output, 1 bit: decoder latch enable, held at constant 0 (decoder transparent).

Function
REQ-015 Counter priority SHALL be LOAD, then EN, then hold.
REQ-016 LOAD=1 SHALL set Q to D on the next edge; any D digit above 9 SHALL load as 0; CO SHALL be 0 on that cycle.
REQ-017 In up-count (EN=1, UP=1), each digit SHALL go from 9 to 0 with a carry into the next digit; 9999 SHALL wrap to 0000, with CO=1 for exactly the one cycle in which Q becomes 0000.
REQ-018 In down-count (EN=1, UP=0), each digit SHALL go from 0 to 9 with a borrow from the next digit; 0000 SHALL wrap to 9999, with CO=1 for exactly the one cycle in which Q becomes 9999.
REQ-019 CO SHALL be 0 on every other cycle; EN held at 1 SHALL count every cycle with no gaps.
REQ-020 The scan divider SHALL count 0 to SCAN_DIV-1 and wrap; at the terminal count, the digit index SHALL advance 0->1->2->3->0.
REQ-021 The scan SHALL run independently of EN, LOAD and UP.
REQ-022 A, DIG_N and BI_N SHALL be registered and recomputed every cycle from the current index and Q, giving 1 cycle of latency from a Q or index change.
REQ-023 DIG_N SHALL be 1110, 1101, 1011 and 0111 for index 0, 1, 2 and 3 respectively.
REQ-024 With LZB=1 and index k>0, BI_N SHALL be 0 when digits k..3 are all zero; the units digit SHALL never be blanked; with LZB=0, BI_N SHALL be 1.
REQ-025 A SHALL carry the digit value even while blanked.
REQ-026 When LOAD or a count occurs in the same cycle as an index advance, the displayed A SHALL reflect the new Q one cycle later, per REQ-022.

Reset
REQ-027 RST_N=0 at a CLK edge SHALL set Q=0000, CO=0, scan divider=0, index=0, A=0, DIG_N=1110, BI_N=1.
REQ-028 Reset SHALL override LOAD and EN.
REQ-029 Reset mid-scan or mid-count SHALL discard all state, with no carry or CO generated.
REQ-030 LE SHALL be 0 in and out of reset.

Structure
REQ-031 A shared package SHALL hold NUM_DIGITS=4, BCD_MAX=9 and the DIG_N one-hot select table.
REQ-032 A sub-module bcd_digit SHALL implement one decade: inputs load/load value, enable, up, carry-in; outputs digit and carry-out.
REQ-033 bcd_digit SHALL be instantiated 4 times in a ripple chain.

Verification (benches SHALL run with SCAN_DIV=4)
REQ-034 Reset: RST_N=0 for 2 cycles, then 1 -> Q=0000, DIG_N=1110, A=0, BI_N=1, CO=0.
REQ-035 Up wrap: LOAD D=9998, then EN=1 and UP=1 for 2 cycles -> Q=9999, then 0000, with CO=1 only in the cycle Q becomes 0000.
REQ-036 Down wrap: LOAD 0001, then EN=1 and UP=0 for 2 cycles -> Q=0000, then 9999, with CO=1 only in the cycle Q becomes 9999; also LOAD 0100 with a down step -> Q=0099.
REQ-037 Invalid load: D=16'hA3F7 -> Q=16'h0307.
REQ-038 Scan: with Q=4321 over 16 cycles, A SHALL read 1, 2, 3, 4 with DIG_N 1110, 1101, 1011, 0111 respectively, each held 4 cycles.
REQ-039 Blanking: with Q=0050 and LZB=1 -> BI_N=0 at indices 2 and 3 and 1 at indices 0 and 1; with LZB=0 -> BI_N=1 throughout; with Q=0000 -> only index 0 is unblanked.
